// File: rtl/sfft_pkg.sv
// Shared types and butterfly address arithmetic for the SFFT stage sequencer.
package sfft_pkg;

    localparam int SFFT_N_LOG2 = 3;
    localparam int SFFT_LAT    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    typedef logic [SFFT_N_LOG2-1:0] addr_t;
    typedef logic [SFFT_N_LOG2-2:0] twid_t;

    typedef struct packed {
        addr_t a;
        addr_t b;
        twid_t k;
    } bfly_t;

    // DIT butterfly for stage s, butterfly index i:
    // a is i with a zero bit inserted at position s, b = a + span,
    // twiddle index is the position within the group scaled to the N/2 ROM.
    function automatic bfly_t bfly_addr(input addr_t stage, input twid_t idx);
        int unsigned s;
        int unsigned i;
        int unsigned span;
        int unsigned pos;
        int unsigned grp;
        int unsigned a;
        bfly_t       r;
        s    = 32'(stage);
        i    = 32'(idx);
        span = 32'd1 << s;
        pos  = i & (span - 32'd1);
        grp  = i >> s;
        a    = (grp << (s + 32'd1)) | pos;
        r.a  = addr_t'(a);
        r.b  = addr_t'(a + span);
        r.k  = twid_t'(pos << (32'(SFFT_N_LOG2) - 32'd1 - s));
        return r;
    endfunction

endpackage

// File: rtl/sfft_write_delay.sv
// Enable-gated shift register carrying {valid, a, b} from read issue to write-back.
module sfft_write_delay #(
    parameter int W     = 7,
    parameter int DEPTH = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Tap 0 is the input; tap gi+1 is the output of stage gi.
    logic [DEPTH:0][W-1:0] w_tap;

    assign w_tap[0] = d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] r_q;

            // One pipeline stage: cleared on reset, frozen while en is low.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_q <= '0;
                end else if (en) begin
                    r_q <= w_tap[gi];
                end
            end

            assign w_tap[gi+1] = r_q;
        end
    endgenerate

    assign q = w_tap[DEPTH];

endmodule

// File: rtl/sfft_stage_sequencer.sv
// Radix-2 in-place SFFT sequencer: issues butterfly read pairs and twiddle
// indices stage by stage, drains the butterfly pipeline between stages so
// every write lands before the next stage reads, and replays each read pair
// as a write-back pair LAT cycles later.
module sfft_stage_sequencer
    import sfft_pkg::*;
#(
    parameter int N_LOG2   = SFFT_N_LOG2,
    parameter int N_POINTS = 1 << N_LOG2,
    parameter int LAT      = SFFT_LAT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              hold,
    output logic [N_LOG2-1:0] read_address_A,
    output logic [N_LOG2-1:0] read_address_B,
    output logic [N_LOG2-2:0] twiddle_k,
    output logic              read_valid,
    output logic [N_LOG2-1:0] write_address_A,
    output logic [N_LOG2-1:0] write_address_B,
    output logic              writeEnable_A,
    output logic              writeEnable_B,
    output logic              pipe_en,
    output logic [N_LOG2-1:0] stage,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W      = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int                WD_W       = 1 + 2 * N_LOG2;
    localparam logic [N_LOG2-2:0] IDX_LAST   = (N_LOG2-1)'(N_POINTS / 2 - 1);
    localparam logic [N_LOG2-1:0] STAGE_LAST = N_LOG2'(N_LOG2 - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(LAT - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic [N_LOG2-1:0] r_stage;
    logic [N_LOG2-1:0] w_stage_next;
    logic [N_LOG2-2:0] r_idx;
    logic [N_LOG2-2:0] w_idx_next;
    logic [CNT_W-1:0]  r_drain;
    logic [CNT_W-1:0]  w_drain_next;
    bfly_t             w_bf;
    bfly_t             r_rd;
    logic              w_rd_valid;
    logic              w_pipe_en;
    logic [WD_W-1:0]   w_wd_in;
    logic [WD_W-1:0]   w_wd_out;
    logic              w_wr_valid;

    // Next-state logic and state-decoded strobes; hold freezes all progress.
    always_comb begin
        w_state_next = r_state;
        w_stage_next = r_stage;
        w_idx_next   = r_idx;
        w_drain_next = r_drain;
        w_pipe_en    = ~hold;
        w_rd_valid   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (r_state)
            IDLE: begin
                if (!hold && start) begin
                    w_state_next = READ;
                    w_stage_next = '0;
                    w_idx_next   = '0;
                end
            end
            READ: begin
                busy       = 1'b1;
                w_rd_valid = ~hold;
                if (!hold) begin
                    if (r_idx == IDX_LAST) begin
                        w_state_next = DRAIN;
                        w_drain_next = '0;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!hold) begin
                    if (r_drain == DRAIN_LAST) begin
                        if (r_stage == STAGE_LAST) begin
                            w_state_next = DONE;
                        end else begin
                            w_state_next = READ;
                            w_stage_next = r_stage + 1'b1;
                            w_idx_next   = '0;
                        end
                    end else begin
                        w_drain_next = r_drain + 1'b1;
                    end
                end
            end
            DONE: begin
                done = ~hold;
                if (!hold) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Address math for the butterfly that will be presented next cycle.
    always_comb begin
        w_bf = bfly_addr(w_stage_next, w_idx_next);
    end

    // State, counters and the registered read-address outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_stage <= '0;
            r_idx   <= '0;
            r_drain <= '0;
            r_rd    <= '0;
        end else begin
            r_state <= w_state_next;
            r_stage <= w_stage_next;
            r_idx   <= w_idx_next;
            r_drain <= w_drain_next;
            r_rd    <= (w_state_next == READ) ? w_bf : '0;
        end
    end

    // Only issued reads enter the write pipeline; idle slots carry zero addresses.
    assign w_wd_in = w_rd_valid ? {1'b1, r_rd.a, r_rd.b} : '0;

    sfft_write_delay #(
        .W     (WD_W),
        .DEPTH (LAT)
    ) u_write_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_pipe_en),
        .d       (w_wd_in),
        .q       (w_wd_out)
    );

    assign {w_wr_valid, write_address_A, write_address_B} = w_wd_out;

    assign writeEnable_A  = w_wr_valid & ~hold;
    assign writeEnable_B  = w_wr_valid & ~hold;
    assign read_valid     = w_rd_valid;
    assign read_address_A = r_rd.a;
    assign read_address_B = r_rd.b;
    assign twiddle_k      = r_rd.k;
    assign pipe_en        = w_pipe_en;
    assign stage          = r_stage;

endmodule

// File: tb/tb_sfft_stage_sequencer.sv
// Self-checking bench for sfft_stage_sequencer (N=8, LAT=3).
// Every cycle is compared against a reference that tracks "unheld cycles since
// start" and derives reads, writes and addresses from plain arithmetic.
module tb_sfft_stage_sequencer;

    localparam int NL       = 3;
    localparam int NP       = 8;
    localparam int LT       = 3;
    localparam int HALF     = NP / 2;
    localparam int PER      = HALF + LT;
    localparam int BUSY_LEN = NL * PER;
    localparam int LOGN     = 80;
    localparam int NV       = 7;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          hold;
    logic [NL-1:0] read_address_A;
    logic [NL-1:0] read_address_B;
    logic [NL-2:0] twiddle_k;
    logic          read_valid;
    logic [NL-1:0] write_address_A;
    logic [NL-1:0] write_address_B;
    logic          writeEnable_A;
    logic          writeEnable_B;
    logic          pipe_en;
    logic [NL-1:0] stage;
    logic          busy;
    logic          done;

    sfft_stage_sequencer #(
        .N_LOG2   (NL),
        .N_POINTS (NP),
        .LAT      (LT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .hold            (hold),
        .read_address_A  (read_address_A),
        .read_address_B  (read_address_B),
        .twiddle_k       (twiddle_k),
        .read_valid      (read_valid),
        .write_address_A (write_address_A),
        .write_address_B (write_address_B),
        .writeEnable_A   (writeEnable_A),
        .writeEnable_B   (writeEnable_B),
        .pipe_en         (pipe_en),
        .stage           (stage),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int hold_lo;
        int hold_hi;
        int extra_start;
        int exp_done_cyc;
        int exp_dones;
        int exp_writes;
        int exp_busy;
    } run_vec_t;

    run_vec_t vec[NV];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    // Reference state: m_e counts unheld cycles since start (0 = idle).
    int m_e    = 0;
    bit m_zero = 1'b1;

    // Butterfly tables built by enumerating pairs whose bit s is clear.
    int bf_a[NL][HALF];
    int bf_b[NL][HALF];
    int bf_k[NL][HALF];

    int log_busy[LOGN];
    int log_done[LOGN];
    int log_rv[LOGN];
    int log_we[LOGN];
    int log_rda[LOGN];
    int log_rdb[LOGN];
    int log_tk[LOGN];
    int log_wra[LOGN];
    int log_wrb[LOGN];
    int log_stage[LOGN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic build_tables();
        for (int s = 0; s < NL; s++) begin
            int n;
            n = 0;
            for (int a = 0; a < NP; a++) begin
                if (((a >> s) & 1) == 0) begin
                    bf_a[s][n] = a;
                    bf_b[s][n] = a + (1 << s);
                    bf_k[s][n] = (a % (1 << s)) * (HALF >> s);
                    n++;
                end
            end
        end
    endtask

    task automatic check_cycle();
        int   e;
        int   we_e;
        logic ex_busy;
        logic ex_done;
        logic ex_rv;
        logic ex_we;
        e       = m_e;
        ex_busy = (e >= 1) && (e <= BUSY_LEN);
        ex_done = (e == BUSY_LEN + 1) && !hold;
        ex_rv   = ex_busy && (((e - 1) % PER) < HALF) && !hold;
        we_e    = e - LT;
        ex_we   = (we_e >= 1) && (we_e <= BUSY_LEN) && (((we_e - 1) % PER) < HALF) && !hold;

        chk("busy", busy, ex_busy);
        chk("done", done, ex_done);
        chk("read_valid", read_valid, ex_rv);
        chk("writeEnable_A", writeEnable_A, ex_we);
        chk("writeEnable_B", writeEnable_B, ex_we);
        chk("pipe_en", pipe_en, !hold);
        if (ex_busy) chk("stage", stage, (e - 1) / PER);
        if (ex_rv) begin
            chk("read_address_A", read_address_A, bf_a[(e-1)/PER][(e-1)%PER]);
            chk("read_address_B", read_address_B, bf_b[(e-1)/PER][(e-1)%PER]);
            chk("twiddle_k", twiddle_k, bf_k[(e-1)/PER][(e-1)%PER]);
        end
        if (ex_we) begin
            chk("write_address_A", write_address_A, bf_a[(we_e-1)/PER][(we_e-1)%PER]);
            chk("write_address_B", write_address_B, bf_b[(we_e-1)/PER][(we_e-1)%PER]);
        end
        if (m_zero) begin
            chk("zero_read_address_A", read_address_A, 0);
            chk("zero_read_address_B", read_address_B, 0);
            chk("zero_twiddle_k", twiddle_k, 0);
            chk("zero_write_address_A", write_address_A, 0);
            chk("zero_write_address_B", write_address_B, 0);
            chk("zero_stage", stage, 0);
        end

        if (cyc < LOGN) begin
            log_busy[cyc]  = int'(busy);
            log_done[cyc]  = int'(done);
            log_rv[cyc]    = int'(read_valid);
            log_we[cyc]    = int'(writeEnable_A);
            log_rda[cyc]   = int'(read_address_A);
            log_rdb[cyc]   = int'(read_address_B);
            log_tk[cyc]    = int'(twiddle_k);
            log_wra[cyc]   = int'(write_address_A);
            log_wrb[cyc]   = int'(write_address_B);
            log_stage[cyc] = int'(stage);
        end
    endtask

    task automatic model_update(input logic st, input logic hd, input logic rn);
        if (!rn) begin
            m_e    = 0;
            m_zero = 1'b1;
        end else if (!hd) begin
            if (m_e == 0) begin
                if (st) begin
                    m_e    = 1;
                    m_zero = 1'b0;
                end
            end else if (m_e == BUSY_LEN + 1) begin
                m_e = 0;
            end else begin
                m_e++;
            end
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance at the rising edge.
    task automatic step(input logic st, input logic hd, input logic rn);
        start   = st;
        hold    = hd;
        reset_n = rn;
        @(negedge clk);
        if (chk_en) check_cycle();
        @(posedge clk);
        model_update(st, hd, rn);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic summarize(output int first_done, output int n_done,
                             output int n_we, output int n_busy);
        first_done = -1;
        n_done     = 0;
        n_we       = 0;
        n_busy     = 0;
        for (int c = 0; c < cyc && c < LOGN; c++) begin
            if (log_done[c] != 0) begin
                if (first_done < 0) first_done = c;
                n_done++;
            end
            n_we   += log_we[c];
            n_busy += log_busy[c];
        end
    endtask

    task automatic row0_details();
        chk("s0i0_a", log_rda[1], 0);
        chk("s0i0_b", log_rdb[1], 1);
        chk("s0i0_k", log_tk[1], 0);
        chk("s1i1_a", log_rda[9], 1);
        chk("s1i1_b", log_rdb[9], 3);
        chk("s1i1_k", log_tk[9], 2);
        chk("s1i2_a", log_rda[10], 4);
        chk("s1i2_b", log_rdb[10], 6);
        chk("s1i2_k", log_tk[10], 0);
        chk("s2i3_a", log_rda[18], 3);
        chk("s2i3_b", log_rdb[18], 7);
        chk("s2i3_k", log_tk[18], 3);
        chk("hazard_read_c4", log_rv[4], 1);
        chk("hazard_write_c7", log_we[7], 1);
        chk("hazard_write_a_c7", log_wra[7], 6);
        chk("hazard_write_b_c7", log_wrb[7], 7);
        chk("hazard_no_read_5_7", log_rv[5] + log_rv[6] + log_rv[7], 0);
        chk("hazard_stage1_read_c8", log_rv[8], 1);
        chk("stage1_c8", log_stage[8], 1);
    endtask

    initial begin
        int fd;
        int nd;
        int nw;
        int nb;

        build_tables();
        vec[0] = '{-1, -1, -1, 22, 1, 12, 21};
        vec[1] = '{ 3,  5, -1, 25, 1, 12, 24};
        vec[2] = '{-1, -1,  5, 22, 1, 12, 21};
        vec[3] = '{-1, -1, 22, 22, 1, 12, 21};
        vec[4] = '{ 0,  0, -1, -1, 0,  0,  0};
        vec[5] = '{19, 20, -1, 24, 1, 12, 23};
        vec[6] = '{22, 23, -1, 24, 1, 12, 21};

        start   = 1'b0;
        hold    = 1'b0;
        reset_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;

        // Table-driven runs: start at cycle 0 with a hold window and an extra start.
        for (int r = 0; r < NV; r++) begin
            do_reset();
            cyc = 0;
            for (int c = 0; c < 60; c++) begin
                step((c == 0) || (c == vec[r].extra_start),
                     (c >= vec[r].hold_lo) && (c <= vec[r].hold_hi), 1'b1);
            end
            summarize(fd, nd, nw, nb);
            chk($sformatf("row%0d_done_cycle", r), fd, vec[r].exp_done_cyc);
            chk($sformatf("row%0d_done_pulses", r), nd, vec[r].exp_dones);
            chk($sformatf("row%0d_write_strobes", r), nw, vec[r].exp_writes);
            chk($sformatf("row%0d_busy_cycles", r), nb, vec[r].exp_busy);
            if (r == 0) row0_details();
        end

        // Reset mid-transform at cycle 10, restart at cycle 12.
        do_reset();
        cyc = 0;
        for (int c = 0; c < 40; c++) begin
            step((c == 0) || (c == 12), 1'b0, c != 10);
        end
        summarize(fd, nd, nw, nb);
        chk("rst_busy_c10", log_busy[10], 1);
        chk("rst_busy_c11", log_busy[11], 0);
        chk("rst_we_c11", log_we[11], 0);
        chk("rst_rda_c11", log_rda[11], 0);
        chk("rst_wra_c11", log_wra[11], 0);
        chk("rst_stage_c11", log_stage[11], 0);
        chk("rst_done_cycle", fd, 34);
        chk("rst_done_pulses", nd, 1);
        chk("rst_write_strobes", nw, 16);
        chk("rst_busy_cycles", nb, 31);

        // Starts at 5 (READ) and 22 (DONE) ignored, start at 23 accepted.
        do_reset();
        cyc = 0;
        for (int c = 0; c < 70; c++) begin
            step((c == 0) || (c == 5) || (c == 22) || (c == 23), 1'b0, 1'b1);
        end
        summarize(fd, nd, nw, nb);
        chk("restart_first_done", fd, 22);
        chk("restart_busy_c23", log_busy[23], 0);
        chk("restart_busy_c24", log_busy[24], 1);
        chk("restart_second_done", log_done[45], 1);
        chk("restart_done_pulses", nd, 2);
        chk("restart_write_strobes", nw, 24);

        // Randomised start/hold/reset traffic against the reference.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 199) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
